// File: rtl/mem_stage_param_if.sv
// MEM-stage bundle: instruction/control inputs from EX/MEM plus the stall
// back-pressure and the registered MEM/WB outputs.
interface mem_stage_param_if;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        reg_write;
  logic        mem_to_reg;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        flush;
  logic        stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_dest_reg;
  logic        wb_misaligned;

  modport master (
    output in_valid, mem_read, mem_write, mem_size, mem_unsigned, reg_write,
           mem_to_reg, alu_result, store_data, dest_reg, flush,
    input  stall, wb_valid, wb_reg_write, wb_mem_to_reg, wb_read_data,
           wb_alu_result, wb_dest_reg, wb_misaligned
  );

  modport slave (
    input  in_valid, mem_read, mem_write, mem_size, mem_unsigned, reg_write,
           mem_to_reg, alu_result, store_data, dest_reg, flush,
    output stall, wb_valid, wb_reg_write, wb_mem_to_reg, wb_read_data,
           wb_alu_result, wb_dest_reg, wb_misaligned
  );
endinterface

// File: rtl/mem_stage_param.sv
// Parameterised MEM pipeline stage: byte-lane data memory, fixed-latency load
// FSM that stalls upstream, and a registered MEM/WB boundary.
module mem_stage_param #(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  mem_stage_param_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(MEM_LAT + 1);
  localparam bit MULTI  = (MEM_LAT > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     word_idx;
  logic [1:0]        lane;
  logic              is_byte, is_half, is_load, is_store;
  logic              misaligned, active, do_write, load_start, stall_c, complete;
  logic [DATA_W-1:0] rd_word, wdata, wmask, load_val;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  logic              nxt_valid, nxt_rw, nxt_m2r, nxt_mis;
  logic [DATA_W-1:0] nxt_rdata, nxt_alu;
  logic [4:0]        nxt_dest;

  // Address decode, lane selection and store merge; a simultaneous read+write is a store.
  always_comb begin
    word_idx   = bus.alu_result[AW+1:2];
    lane       = bus.alu_result[1:0];
    is_byte    = (bus.mem_size == 2'b00);
    is_half    = (bus.mem_size == 2'b01);
    is_store   = bus.mem_write;
    is_load    = bus.mem_read & ~bus.mem_write;
    misaligned = (is_store | is_load) &
                 ((is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00)));
    active     = bus.in_valid & ~bus.flush;
    do_write   = active & is_store & ~misaligned;
    load_start = MULTI & active & is_load & ~misaligned;
    rd_word    = mem[word_idx];
    byte_sel   = rd_word[{lane, 3'b000} +: 8];
    half_sel   = rd_word[{lane[1], 4'b0000} +: 16];
    if (is_byte) begin
      load_val = {{24{~bus.mem_unsigned & byte_sel[7]}}, byte_sel};
      wdata    = {4{bus.store_data[7:0]}};
      wmask    = 32'h0000_00FF << {lane, 3'b000};
    end else if (is_half) begin
      load_val = {{16{~bus.mem_unsigned & half_sel[15]}}, half_sel};
      wdata    = {2{bus.store_data[15:0]}};
      wmask    = 32'h0000_FFFF << {lane[1], 4'b0000};
    end else begin
      load_val = rd_word;
      wdata    = bus.store_data;
      wmask    = 32'hFFFF_FFFF;
    end
  end

  // Next-state logic; flush overrides everything and releases the stall at once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_d = BUSY;
            cnt_d   = CW'(MEM_LAT - 1);
            stall_c = 1'b1;
          end
        end
        BUSY: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q > CW'(1)) stall_c = 1'b1;
          else                state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.stall = reset & stall_c;

  always_comb begin
    complete  = active & ~stall_c;
    nxt_valid = complete;
    nxt_mis   = complete & misaligned;
    nxt_rw    = complete & ~misaligned & bus.reg_write;
    nxt_m2r   = complete & bus.mem_to_reg;
    nxt_alu   = complete ? bus.alu_result : '0;
    nxt_dest  = complete ? bus.dest_reg : '0;
    nxt_rdata = (complete & is_load & ~misaligned) ? load_val : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else if (do_write) begin
      mem[word_idx] <= (rd_word & ~wmask) | (wdata & wmask);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.wb_valid      <= 1'b0;
      bus.wb_reg_write  <= 1'b0;
      bus.wb_mem_to_reg <= 1'b0;
      bus.wb_misaligned <= 1'b0;
      bus.wb_read_data  <= '0;
      bus.wb_alu_result <= '0;
      bus.wb_dest_reg   <= '0;
    end else begin
      bus.wb_valid      <= nxt_valid;
      bus.wb_reg_write  <= nxt_rw;
      bus.wb_mem_to_reg <= nxt_m2r;
      bus.wb_misaligned <= nxt_mis;
      bus.wb_read_data  <= nxt_rdata;
      bus.wb_alu_result <= nxt_alu;
      bus.wb_dest_reg   <= nxt_dest;
    end
  end
endmodule

// File: tb/tb_mem_stage_param.sv
// Bench for mem_stage_param: two instances (latency 2 / depth 256 and latency 4 /
// depth 16) checked against a byte-addressed reference memory.
module tb_mem_stage_param;
  localparam int D2 = 256;
  localparam int L2 = 2;
  localparam int D4 = 16;
  localparam int L4 = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_stage_param_if bus2 ();
  mem_stage_param_if bus4 ();

  mem_stage_param #(.DEPTH(D2), .MEM_LAT(L2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mem_stage_param #(.DEPTH(D4), .MEM_LAT(L4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  typedef struct packed {
    logic        valid, rd, wr;
    logic [1:0]  size;
    logic        uns, rw, m2r;
    logic [31:0] addr, sdata;
    logic [4:0]  dest;
  } op_t;

  typedef struct packed {
    logic        valid, rw, m2r, misal;
    logic [31:0] rdata, alu;
    logic [4:0]  dest;
  } wb_t;

  logic [7:0] m2 [D2*4];
  logic [7:0] m4 [D4*4];
  int vectors = 0;
  int miscompares = 0;

  function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic rw);
    op_t o;
    o       = '0;
    o.valid = 1'b1;
    o.rd    = rd;
    o.wr    = wr;
    o.size  = size;
    o.uns   = uns;
    o.addr  = addr;
    o.sdata = sdata;
    o.rw    = rw;
    o.m2r   = rd;
    o.dest  = addr[6:2] ^ 5'h0A;
    return o;
  endfunction

  task automatic drive(input int which, input op_t op, input logic fl);
    if (which == 2) begin
      bus2.in_valid = op.valid; bus2.mem_read = op.rd; bus2.mem_write = op.wr;
      bus2.mem_size = op.size; bus2.mem_unsigned = op.uns; bus2.reg_write = op.rw;
      bus2.mem_to_reg = op.m2r; bus2.alu_result = op.addr; bus2.store_data = op.sdata;
      bus2.dest_reg = op.dest; bus2.flush = fl;
    end else begin
      bus4.in_valid = op.valid; bus4.mem_read = op.rd; bus4.mem_write = op.wr;
      bus4.mem_size = op.size; bus4.mem_unsigned = op.uns; bus4.reg_write = op.rw;
      bus4.mem_to_reg = op.m2r; bus4.alu_result = op.addr; bus4.store_data = op.sdata;
      bus4.dest_reg = op.dest; bus4.flush = fl;
    end
  endtask

  function automatic wb_t sample(input int which);
    wb_t w;
    if (which == 2) begin
      w.valid = bus2.wb_valid; w.rw = bus2.wb_reg_write; w.m2r = bus2.wb_mem_to_reg;
      w.misal = bus2.wb_misaligned; w.rdata = bus2.wb_read_data;
      w.alu = bus2.wb_alu_result; w.dest = bus2.wb_dest_reg;
    end else begin
      w.valid = bus4.wb_valid; w.rw = bus4.wb_reg_write; w.m2r = bus4.wb_mem_to_reg;
      w.misal = bus4.wb_misaligned; w.rdata = bus4.wb_read_data;
      w.alu = bus4.wb_alu_result; w.dest = bus4.wb_dest_reg;
    end
    return w;
  endfunction

  function automatic logic stall_of(input int which);
    return (which == 2) ? bus2.stall : bus4.stall;
  endfunction

  // Reference: byte-addressed memory, results built byte by byte from the access rules.
  task automatic model(input int which, input op_t op, output wb_t exp, output int exp_stalls);
    int nb, base, depth_b;
    logic [31:0] v;
    bit ld, st, acc, mis;
    exp = '0;
    exp_stalls = 0;
    if (!op.valid) return;
    depth_b = (which == 2) ? D2 * 4 : D4 * 4;
    st  = op.wr;
    ld  = op.rd && !op.wr;
    acc = st || ld;
    nb  = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : 4;
    mis = acc && ((op.addr % 32'(nb)) != 0);
    base = int'(op.addr % 32'(depth_b));
    exp.valid = 1'b1;
    exp.misal = mis;
    exp.rw    = mis ? 1'b0 : op.rw;
    exp.m2r   = op.m2r;
    exp.alu   = op.addr;
    exp.dest  = op.dest;
    if (mis) return;
    if (st) begin
      for (int k = 0; k < nb; k++) begin
        if (which == 2) m2[base+k] = op.sdata[8*k +: 8];
        else            m4[base+k] = op.sdata[8*k +: 8];
      end
    end else if (ld) begin
      v = '0;
      for (int k = 0; k < nb; k++)
        v = v | (32'((which == 2) ? m2[base+k] : m4[base+k]) << (8 * k));
      if (!op.uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      exp.rdata  = v;
      exp_stalls = ((which == 2) ? L2 : L4) - 1;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < D2 * 4; i++) m2[i] = 8'h00;
    for (int i = 0; i < D4 * 4; i++) m4[i] = 8'h00;
  endtask

  // Presents one instruction, counts stall cycles (bounded) and samples the completion edge.
  task automatic exec(input int which, input op_t op, output int stalls, output wb_t wb,
                      output bit tmo);
    stalls = 0;
    tmo = 1'b0;
    drive(which, op, 1'b0);
    @(negedge clk);
    while (stall_of(which) === 1'b1) begin
      stalls++;
      if (stalls > 16) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    wb = sample(which);
    drive(which, '0, 1'b0);
  endtask

  task automatic test_reset();
    drive(2, mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1), 1'b0);
    @(posedge clk);
    #1;
    vectors++;
    if (bus2.stall !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_stall: got %b expected 0", bus2.stall);
    end
    vectors++;
    if ({bus2.wb_valid, bus2.wb_reg_write, bus2.wb_misaligned, bus2.wb_read_data} !== 35'd0) begin
      miscompares++; $display("[TB] FAIL reset_wb2: valid=%b data=%h expected all 0",
                              bus2.wb_valid, bus2.wb_read_data);
    end
    vectors++;
    if ({bus4.wb_valid, bus4.wb_alu_result, bus4.wb_dest_reg} !== 38'd0) begin
      miscompares++; $display("[TB] FAIL reset_wb4: valid=%b alu=%h expected all 0",
                              bus4.wb_valid, bus4.wb_alu_result);
    end
    drive(2, '0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mem_ops();
    op_t op; wb_t wb, exp; int st, es; bit tmo;
    logic [31:0] want [5];
    op_t ld_ops [5];
    op = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    model(2, op, exp, es);
    exec(2, op, st, wb, tmo);
    vectors++;
    if (st !== 0 || wb.valid !== 1'b1 || tmo) begin
      miscompares++; $display("[TB] FAIL word_store: stalls=%0d valid=%b expected 0/1", st, wb.valid);
    end
    op = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    model(2, op, exp, es);
    exec(2, op, st, wb, tmo);
    vectors++;
    if (st !== 1 || tmo) begin
      miscompares++; $display("[TB] FAIL word_load_stall: got %0d cycles expected 1", st);
    end
    vectors++;
    if (wb.rdata !== 32'hDEADBEEF || wb.valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL word_load: got %h expected deadbeef", wb.rdata);
    end
    op = mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, 1'b0);
    model(2, op, exp, es);
    exec(2, op, st, wb, tmo);
    ld_ops[0] = mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1); want[0] = 32'hFFFF_FF80;
    ld_ops[1] = mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1); want[1] = 32'h0000_0080;
    ld_ops[2] = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1); want[2] = 32'h80AD_BEEF;
    ld_ops[3] = mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1); want[3] = 32'hFFFF_80AD;
    ld_ops[4] = mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b1); want[4] = 32'h0000_BEEF;
    for (int i = 0; i < 5; i++) begin
      model(2, ld_ops[i], exp, es);
      exec(2, ld_ops[i], st, wb, tmo);
      vectors++;
      if (wb.rdata !== want[i] || st !== 1 || tmo) begin
        miscompares++; $display("[TB] FAIL subword_load%0d: got %h stalls=%0d expected %h stalls=1",
                                i, wb.rdata, st, want[i]);
      end
    end
    op = mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1'b1);
    model(2, op, exp, es);
    exec(2, op, st, wb, tmo);
    vectors++;
    if (st !== 0 || wb.misal !== 1'b1 || wb.rw !== 1'b0 || wb.valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL misaligned_half: stalls=%0d mis=%b rw=%b valid=%b expected 0/1/0/1",
                              st, wb.misal, wb.rw, wb.valid);
    end
    op = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h12, 32'h1111_1111, 1'b1);
    model(2, op, exp, es);
    exec(2, op, st, wb, tmo);
    vectors++;
    if (wb.misal !== 1'b1 || wb.rw !== 1'b0) begin
      miscompares++; $display("[TB] FAIL misaligned_store: mis=%b rw=%b expected 1/0", wb.misal, wb.rw);
    end
    op = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    model(2, op, exp, es);
    exec(2, op, st, wb, tmo);
    vectors++;
    if (wb.rdata !== 32'h80AD_BEEF) begin
      miscompares++; $display("[TB] FAIL memory_unchanged: got %h expected 80adbeef", wb.rdata);
    end
  endtask

  task automatic test_wrap();
    op_t op; wb_t wb, exp; int st, es; bit tmo;
    op = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'(D4 * 4 + 8), 32'h1234_5678, 1'b0);
    model(4, op, exp, es);
    exec(4, op, st, wb, tmo);
    op = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b1);
    model(4, op, exp, es);
    exec(4, op, st, wb, tmo);
    vectors++;
    if (wb.rdata !== 32'h1234_5678 || tmo) begin
      miscompares++; $display("[TB] FAIL wrap_store: got %h expected 12345678", wb.rdata);
    end
    vectors++;
    if (st !== L4 - 1) begin
      miscompares++; $display("[TB] FAIL lat4_stall: got %0d cycles expected %0d", st, L4 - 1);
    end
  endtask

  task automatic test_flush();
    op_t op; wb_t wb, exp; int st, es; bit tmo;
    op = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
    drive(4, op, 1'b0);
    @(negedge clk);
    vectors++;
    if (bus4.stall !== 1'b1) begin
      miscompares++; $display("[TB] FAIL flush_pre_stall: got %b expected 1", bus4.stall);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus4.wb_valid !== 1'b0 || bus4.wb_reg_write !== 1'b0) begin
      miscompares++; $display("[TB] FAIL stall_bubble: valid=%b rw=%b expected 0/0",
                              bus4.wb_valid, bus4.wb_reg_write);
    end
    drive(4, op, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus4.stall !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_stall: got %b expected 0", bus4.stall);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({bus4.wb_valid, bus4.wb_reg_write, bus4.wb_misaligned} !== 3'b000) begin
      miscompares++; $display("[TB] FAIL flush_bubble: got %b expected 000",
                              {bus4.wb_valid, bus4.wb_reg_write, bus4.wb_misaligned});
    end
    drive(4, '0, 1'b0);
    model(4, op, exp, es);
    exec(4, op, st, wb, tmo);
    vectors++;
    if (st !== es || wb.valid !== 1'b1 || wb.rdata !== exp.rdata || tmo) begin
      miscompares++; $display("[TB] FAIL after_flush_load: stalls=%0d data=%h expected %0d/%h",
                              st, wb.rdata, es, exp.rdata);
    end
    op = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h24, 32'hFFFF_FFFF, 1'b1);
    drive(4, op, 1'b1);
    @(posedge clk);
    #1;
    vectors++;
    if (bus4.wb_valid !== 1'b0 || bus4.wb_reg_write !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flushed_store_wb: valid=%b rw=%b expected 0/0",
                              bus4.wb_valid, bus4.wb_reg_write);
    end
    drive(4, '0, 1'b0);
    op = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b1);
    model(4, op, exp, es);
    exec(4, op, st, wb, tmo);
    vectors++;
    if (wb.rdata !== exp.rdata) begin
      miscompares++; $display("[TB] FAIL flushed_store_mem: got %h expected %h", wb.rdata, exp.rdata);
    end
  endtask

  task automatic test_back_to_back();
    op_t op; wb_t wb, exp; int st, es; bit tmo;
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      op = mk(1'b0, 1'b1, 2'd2, 1'b0, a + 32'h100, $urandom, 1'b0);
      model(2, op, exp, es);
      exec(2, op, st, wb, tmo);
      op = mk(1'b0, 1'b1, 2'd0, 1'b0, a + 32'h100 + 32'($urandom_range(0, 3)), $urandom, 1'b0);
      model(2, op, exp, es);
      exec(2, op, st, wb, tmo);
      op = mk(1'b1, 1'b0, 2'd2, 1'b0, a + 32'h100, 32'h0, 1'b1);
      model(2, op, exp, es);
      exec(2, op, st, wb, tmo);
      vectors++;
      if (wb.rdata !== exp.rdata || tmo) begin
        miscompares++; $display("[TB] FAIL back_to_back%0d: got %h expected %h", i, wb.rdata, exp.rdata);
      end
    end
  endtask

  task automatic test_random();
    op_t op; wb_t wb, exp; int st, es; bit tmo;
    for (int i = 0; i < 80; i++) begin
      op = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              (32'($urandom_range(0, 3)) << 10) | 32'($urandom_range(0, 31)),
              $urandom, 1'($urandom_range(0, 1)));
      op.valid = ($urandom_range(0, 7) != 0);
      op.m2r   = 1'($urandom_range(0, 1));
      op.dest  = 5'($urandom_range(0, 31));
      model(2, op, exp, es);
      exec(2, op, st, wb, tmo);
      vectors++;
      if (st !== es || tmo) begin
        miscompares++; $display("[TB] FAIL rand%0d_stall: got %0d expected %0d", i, st, es);
      end
      vectors++;
      if ({wb.valid, wb.rw, wb.misal} !== {exp.valid, exp.rw, exp.misal}) begin
        miscompares++; $display("[TB] FAIL rand%0d_ctrl: got %b expected %b", i,
                                {wb.valid, wb.rw, wb.misal}, {exp.valid, exp.rw, exp.misal});
      end
      if (exp.valid && !exp.misal) begin
        vectors++;
        if ({wb.rdata, wb.alu, wb.dest, wb.m2r} !== {exp.rdata, exp.alu, exp.dest, exp.m2r}) begin
          miscompares++; $display("[TB] FAIL rand%0d_data: got %h/%h/%0d/%b expected %h/%h/%0d/%b", i,
                                  wb.rdata, wb.alu, wb.dest, wb.m2r,
                                  exp.rdata, exp.alu, exp.dest, exp.m2r);
        end
      end
    end
  endtask

  task automatic test_reset_busy();
    op_t op2, op4; wb_t wb, exp; int st, es; bit tmo;
    op4 = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b1);
    op2 = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b1);
    drive(4, op4, 1'b0);
    drive(2, op2, 1'b0);
    @(posedge clk);
    #1;
    drive(2, '0, 1'b0);
    vectors++;
    if (bus2.wb_valid !== 1'b1 || bus4.stall !== 1'b1) begin
      miscompares++; $display("[TB] FAIL pre_reset: valid=%b stall=%b expected 1/1",
                              bus2.wb_valid, bus4.stall);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus2.wb_valid, bus2.wb_reg_write, bus2.wb_alu_result, bus2.wb_dest_reg} !== 39'd0) begin
      miscompares++; $display("[TB] FAIL async_reset_wb: valid=%b alu=%h expected 0/0",
                              bus2.wb_valid, bus2.wb_alu_result);
    end
    vectors++;
    if (bus4.stall !== 1'b0) begin
      miscompares++; $display("[TB] FAIL async_reset_stall: got %b expected 0", bus4.stall);
    end
    clear_model();
    drive(4, '0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model(4, op4, exp, es);
    exec(4, op4, st, wb, tmo);
    vectors++;
    if (st !== L4 - 1 || wb.valid !== 1'b1 || wb.rdata !== 32'h0 || tmo) begin
      miscompares++; $display("[TB] FAIL post_reset_load: stalls=%0d data=%h expected %0d/00000000",
                              st, wb.rdata, L4 - 1);
    end
    op2 = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    model(2, op2, exp, es);
    exec(2, op2, st, wb, tmo);
    vectors++;
    if (wb.rdata !== 32'h0 || st !== L2 - 1) begin
      miscompares++; $display("[TB] FAIL reset_clears_mem: got %h expected 00000000", wb.rdata);
    end
  endtask

  initial begin
    clear_model();
    drive(2, '0, 1'b0);
    drive(4, '0, 1'b0);
    test_reset();
    test_mem_ops();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
